// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst adaptor: turns one 256-bit line read/write from the
// cache into a BEATS-beat burst on the memory side, with a one-cycle resp_o pulse.
module cacheline_adaptor #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [255:0]      line_i,
  output logic [255:0]      line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic [255:0]  line_q;
  logic [255:0]  buf_q;
  logic [31:0]   addr_q;
  logic          read_q;
  logic          write_q;
  logic          resp_q;

  // Handshake outputs are flopped alongside the state so they track it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      line_q  <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (write_i) begin
            state_q <= WRITE;
            write_q <= 1'b1;
            addr_q  <= address_i & 32'hFFFF_FFE0;
            buf_q   <= line_i;
            k_q     <= '0;
          end else if (read_i) begin
            state_q <= READ;
            read_q  <= 1'b1;
            addr_q  <= address_i & 32'hFFFF_FFE0;
            k_q     <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            line_q[k_q*BEAT_W +: BEAT_W] <= burst_i;
            if (k_q == K_LAST) begin
              state_q <= DONE;
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              k_q     <= '0;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (k_q == K_LAST) begin
              state_q <= DONE;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              k_q     <= '0;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;
  assign burst_o   = write_q ? buf_q[k_q*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios plus randomized
// line transfers checked against a beat-level reference model.
module tb_cacheline_adaptor;

  localparam int NB = 4;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int tests;
  int fails;

  logic [63:0] wr_pres[$];
  logic [63:0] wr_acc[$];
  bit          wr_pat[$];
  int          wr_rd_seen;
  int          wr_bo_nz;

  cacheline_adaptor #(.BEATS(4), .BEAT_W(64)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Memory-side responder for a line read; cycle 1 is the IDLE cycle that samples read_i.
  task automatic run_read(input logic [31:0] addr, input logic [255:0] data, input int gap_pct,
                          output int lat, output int rd_cyc, output int stalls,
                          output int resp_cnt, output logic [31:0] addr_seen, output bit to);
    int beat;
    beat = 0; lat = 0; rd_cyc = 0; stalls = 0; resp_cnt = 0; addr_seen = '0; to = 1'b1;
    address_i = addr; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b0;
    for (int cyc = 2; cyc <= 200; cyc++) begin
      tick;
      if (resp_o) begin
        resp_cnt++; lat = cyc; to = 1'b0;
        read_i = 1'b0; resp_i = 1'b0;
        break;
      end
      if (read_o) begin
        rd_cyc++;
        addr_seen = address_o;
        if (beat < NB && $urandom_range(0, 99) >= gap_pct) begin
          resp_i = 1'b1; burst_i = data[beat*64 +: 64]; beat++;
        end else begin
          resp_i = 1'b0; burst_i = {$urandom, $urandom}; stalls++;
        end
      end else begin
        resp_i = 1'b0;
      end
    end
    read_i = 1'b0;
    tick;
    if (resp_o) resp_cnt++;
  endtask

  // Memory-side acceptor for a line write; pattern bits (LSB first) pick accept cycles,
  // falling back to random gaps once the pattern runs out.
  task automatic run_write(input logic [31:0] addr, input logic [255:0] data,
                           input logic [15:0] pat, input int patlen, input int gap_pct,
                           output int lat, output int resp_cnt, output bit to);
    int idx;
    bit acc;
    idx = 0; lat = 0; resp_cnt = 0; to = 1'b1;
    wr_pres.delete(); wr_acc.delete(); wr_pat.delete();
    wr_rd_seen = 0; wr_bo_nz = 0;
    address_i = addr; line_i = data; write_i = 1'b1; resp_i = 1'b0;
    for (int cyc = 2; cyc <= 200; cyc++) begin
      tick;
      if (read_o) wr_rd_seen++;
      if (resp_o) begin
        if (burst_o !== 64'd0) wr_bo_nz++;
        resp_cnt++; lat = cyc; to = 1'b0;
        write_i = 1'b0; read_i = 1'b0; resp_i = 1'b0;
        break;
      end
      if (write_o) begin
        wr_pres.push_back(burst_o);
        if (idx < patlen) acc = pat[idx];
        else acc = ($urandom_range(0, 99) >= gap_pct);
        idx++;
        wr_pat.push_back(acc);
        resp_i = acc;
        if (acc) wr_acc.push_back(burst_o);
      end else begin
        if (burst_o !== 64'd0) wr_bo_nz++;
        resp_i = 1'b0;
      end
    end
    write_i = 1'b0; read_i = 1'b0;
    tick;
    if (resp_o) resp_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;
    tick; tick;
    rst = 1'b0;
    tests++; if (line_o !== 256'd0) begin fails++; $display("FAIL reset_line_o got %h want 0", line_o); end
    tests++; if (address_o !== 32'd0) begin fails++; $display("FAIL reset_address_o got %h want 0", address_o); end
    tests++; if ({read_o, write_o, resp_o} !== 3'b000) begin fails++; $display("FAIL reset_strobes got %b want 000", {read_o, write_o, resp_o}); end
    tests++; if (burst_o !== 64'd0) begin fails++; $display("FAIL reset_burst_o got %h want 0", burst_o); end
    tick;
    tests++; if ({read_o, write_o, resp_o} !== 3'b000) begin fails++; $display("FAIL reset_idle_hold got %b want 000", {read_o, write_o, resp_o}); end
  endtask

  task automatic test_read_zero_gap;
    logic [255:0] d;
    logic [31:0] as;
    int lat, rc, st, rs;
    bit to;
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_read(32'h0000_1234, d, 0, lat, rc, st, rs, as, to);
    tests++; if (to) begin fails++; $display("FAIL read0_timeout got no resp_o want resp_o"); end
    tests++; if (as !== 32'h0000_1220) begin fails++; $display("FAIL read0_address got %h want 00001220", as); end
    tests++; if (rc != 4) begin fails++; $display("FAIL read0_read_o_cycles got %0d want 4", rc); end
    tests++; if (lat != 6) begin fails++; $display("FAIL read0_latency got %0d want 6", lat); end
    tests++; if (rs != 1) begin fails++; $display("FAIL read0_resp_pulses got %0d want 1", rs); end
    tests++; if (line_o !== d) begin fails++; $display("FAIL read0_line got %h want %h", line_o, d); end
  endtask

  task automatic test_write_stalls;
    logic [255:0] d;
    logic [63:0] exp_pres[7];
    int lat, rs;
    bit to;
    d = rand_line();
    exp_pres = '{d[63:0], d[127:64], d[127:64], d[127:64], d[191:128], d[255:192], d[255:192]};
    run_write(32'hABCD_EF7F, d, 16'b0000_0000_0100_1001 | 16'b0000_0000_0001_0000, 7, 0, lat, rs, to);
    tests++; if (to) begin fails++; $display("FAIL wstall_timeout got no resp_o want resp_o"); end
    tests++; if (wr_pres.size() != 7) begin fails++; $display("FAIL wstall_write_o_cycles got %0d want 7", wr_pres.size()); end
    for (int i = 0; i < 7 && i < wr_pres.size(); i++) begin
      tests++;
      if (wr_pres[i] !== exp_pres[i]) begin fails++; $display("FAIL wstall_burst_o[%0d] got %h want %h", i, wr_pres[i], exp_pres[i]); end
    end
    tests++; if (rs != 1) begin fails++; $display("FAIL wstall_resp_pulses got %0d want 1", rs); end
    tests++; if (lat != 9) begin fails++; $display("FAIL wstall_latency got %0d want 9", lat); end
    tests++; if (address_o !== 32'hABCD_EF60) begin fails++; $display("FAIL wstall_address got %h want abcdef60", address_o); end
    tests++; if (wr_bo_nz != 0) begin fails++; $display("FAIL wstall_burst_idle_zero got %0d nonzero cycles want 0", wr_bo_nz); end
  endtask

  task automatic test_both_requests;
    logic [255:0] d;
    int lat, rs;
    bit to;
    d = rand_line();
    read_i = 1'b1;
    run_write(32'h0000_0040, d, 16'h0000, 0, 0, lat, rs, to);
    tests++; if (to) begin fails++; $display("FAIL both_timeout got no resp_o want resp_o"); end
    tests++; if (wr_rd_seen != 0) begin fails++; $display("FAIL both_read_o got %0d cycles high want 0", wr_rd_seen); end
    tests++; if (wr_acc.size() != 4) begin fails++; $display("FAIL both_accepts got %0d want 4", wr_acc.size()); end
    tests++; if (lat != 6) begin fails++; $display("FAIL both_latency got %0d want 6", lat); end
  endtask

  task automatic test_back_to_back;
    logic [255:0] a, b;
    int beat;
    bit seen;
    a = rand_line(); b = rand_line();
    address_i = 32'h0000_2000; read_i = 1'b1; resp_i = 1'b0;
    beat = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      tick;
      if (resp_o) begin seen = 1'b1; resp_i = 1'b0; break; end
      resp_i = read_o && beat < NB;
      if (resp_i) begin burst_i = a[beat*64 +: 64]; beat++; end
    end
    tests++; if (!seen) begin fails++; $display("FAIL b2b_first_timeout got no resp_o want resp_o"); end
    tests++; if (line_o !== a) begin fails++; $display("FAIL b2b_first_line got %h want %h", line_o, a); end
    tick;
    tests++; if ({read_o, resp_o} !== 2'b00) begin fails++; $display("FAIL b2b_idle_gap got %b want 00", {read_o, resp_o}); end
    tick;
    tests++; if (read_o !== 1'b1) begin fails++; $display("FAIL b2b_reassert got %b want 1", read_o); end
    tick;
    tests++; if (line_o !== a) begin fails++; $display("FAIL b2b_hold_old got %h want %h", line_o, a); end
    resp_i = 1'b1; burst_i = b[63:0]; read_i = 1'b0;
    tick;
    tests++; if (line_o !== {a[255:64], b[63:0]}) begin fails++; $display("FAIL b2b_beat0 got %h want %h", line_o, {a[255:64], b[63:0]}); end
    for (int i = 1; i < NB; i++) begin
      burst_i = b[i*64 +: 64];
      tick;
    end
    resp_i = 1'b0;
    tests++; if (resp_o !== 1'b1) begin fails++; $display("FAIL b2b_second_resp got %b want 1", resp_o); end
    tests++; if (line_o !== b) begin fails++; $display("FAIL b2b_second_line got %h want %h", line_o, b); end
    tick;
  endtask

  task automatic test_reset_mid_burst;
    logic [255:0] d;
    logic [31:0] as;
    int lat, rc, st, rs;
    bit to;
    d = rand_line();
    address_i = 32'h0000_3000; read_i = 1'b1; resp_i = 1'b0;
    tick;
    resp_i = 1'b1; burst_i = d[63:0];
    tick;
    burst_i = d[127:64];
    tick;
    resp_i = 1'b0; read_i = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    tests++; if (line_o !== 256'd0) begin fails++; $display("FAIL rstmid_line got %h want 0", line_o); end
    tests++; if ({read_o, resp_o} !== 2'b00) begin fails++; $display("FAIL rstmid_strobes got %b want 00", {read_o, resp_o}); end
    tick;
    tests++; if (resp_o !== 1'b0) begin fails++; $display("FAIL rstmid_no_resp got %b want 0", resp_o); end
    d = rand_line();
    run_read(32'h0000_3000, d, 0, lat, rc, st, rs, as, to);
    tests++; if (to || lat != 6) begin fails++; $display("FAIL rstmid_reread_latency got %0d want 6", lat); end
    tests++; if (line_o !== d) begin fails++; $display("FAIL rstmid_reread_line got %h want %h", line_o, d); end
  endtask

  task automatic test_spurious_resp;
    logic [255:0] held;
    logic [31:0] as;
    int lat, rc, st, rs;
    bit to;
    held = line_o;
    read_i = 1'b0; write_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      tick;
      tests++; if ({read_o, write_o, resp_o} !== 3'b000) begin fails++; $display("FAIL spur_strobes got %b want 000", {read_o, write_o, resp_o}); end
      tests++; if (line_o !== held) begin fails++; $display("FAIL spur_line got %h want %h", line_o, held); end
    end
    resp_i = 1'b0;
    held = rand_line();
    run_read(32'h0000_4010, held, 0, lat, rc, st, rs, as, to);
    tests++; if (to || lat != 6 || line_o !== held) begin fails++; $display("FAIL spur_followup got lat %0d line %h want lat 6 line %h", lat, line_o, held); end
  endtask

  task automatic test_random;
    logic [255:0] d;
    logic [31:0] a, as;
    logic [63:0] e;
    int lat, rc, st, rs, gap, nacc;
    bit to;
    for (int t = 0; t < 16; t++) begin
      d = rand_line(); a = $urandom; gap = $urandom_range(0, 60);
      if ($urandom_range(0, 1) == 0) begin
        run_read(a, d, gap, lat, rc, st, rs, as, to);
        tests++;
        if (to || line_o !== d || as !== (a & 32'hFFFF_FFE0) || rc != NB + st || lat != 2 + NB + st || rs != 1) begin
          fails++;
          $display("FAIL rand_read[%0d] got line %h addr %h lat %0d resp %0d want line %h addr %h lat %0d resp 1",
                   t, line_o, as, lat, rs, d, a & 32'hFFFF_FFE0, 2 + NB + st);
        end
      end else begin
        run_write(a, d, 16'h0000, 0, gap, lat, rs, to);
        nacc = 0;
        for (int i = 0; i < wr_pres.size(); i++) begin
          e = d[(nacc % NB)*64 +: 64];
          tests++;
          if (wr_pres[i] !== e) begin fails++; $display("FAIL rand_write[%0d] beat cycle %0d got %h want %h", t, i, wr_pres[i], e); end
          if (wr_pat[i]) nacc++;
        end
        tests++;
        if (to || nacc != NB || lat != 2 + wr_pres.size() || rs != 1 || address_o !== (a & 32'hFFFF_FFE0) || wr_bo_nz != 0) begin
          fails++;
          $display("FAIL rand_write[%0d] got accepts %0d lat %0d resp %0d addr %h want accepts 4 lat %0d resp 1 addr %h",
                   t, nacc, lat, rs, address_o, 2 + wr_pres.size(), a & 32'hFFFF_FFE0);
        end
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;
    test_reset;
    test_read_zero_gap;
    test_write_stalls;
    test_both_requests;
    test_back_to_back;
    test_reset_mid_burst;
    test_spurious_resp;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The block SHALL have these ports, one clock domain; reset is synchronous and active-high:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous active-high reset
- line_i  input  256  write line from cache
- line_o  output  256  assembled read line to cache
- address_i  input  32  cache line address
- read_i  input  1  cache line-read request, held until resp_o
- write_i  input  1  cache line-write request, held until resp_o
- resp_o  output  1  one-cycle completion pulse to cache
- burst_i  input  64  read beat from memory
- burst_o  output  64  write beat to memory
- address_o  output  32  burst address to memory
- read_o  output  1  burst read request to memory
- write_o  output  1  burst write request to memory
- resp_i  input  1  memory beat-valid / beat-accept strobe
REQ-002 The block SHALL have these parameters:
- BEATS, default 4, beats per line
- BEAT_W, default 64, bits per beat; BEATS*BEAT_W SHALL equal 256.

Function
REQ-003 The block SHALL act as the responder for the cache's physical-memory line interface. It SHALL convert each 256-bit line transfer into one BEATS-beat burst on the memory side.
REQ-004 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
REQ-005 In IDLE, write_i=1 SHALL move the FSM to WRITE. Otherwise read_i=1 SHALL move it to READ. If both are asserted, write SHALL win.
REQ-006 On leaving IDLE, the block SHALL latch:
- address_o = {address_i[31:5], 5'b0}
- line_i into an internal buffer (write only)
- beat counter = 0
REQ-007 address_o SHALL hold its latched value until the next request is accepted.
REQ-008 read_o SHALL be 1 exactly while the state is READ. write_o SHALL be 1 exactly while the state is WRITE. Both are registered-state decodes with no combinational path from read_i or write_i.
REQ-009 In READ, each cycle with resp_i=1 SHALL capture burst_i into line_o[64k+63:64k], where k is the beat counter, and then increment k.
REQ-010 In WRITE, burst_o SHALL equal buffer[64k+63:64k] combinationally from k. Each cycle with resp_i=1 SHALL increment k.
REQ-011 In READ or WRITE, a resp_i=0 cycle SHALL stall: k and the state are unchanged, and gaps between beats are legal.
REQ-012 When resp_i=1 with k=BEATS-1, the FSM SHALL go to DONE next cycle, and k SHALL wrap to 0.
REQ-013 In DONE, resp_o SHALL be 1 for exactly one cycle. The FSM SHALL then return to IDLE unconditionally.
REQ-014 read_i and write_i SHALL be ignored outside IDLE. A request still high in the cycle after DONE SHALL start a new transfer.
REQ-015 line_o SHALL hold the last completed read line, stable from DONE until the next READ beat 0 is captured.
REQ-016 Latency with zero-gap memory SHALL be 1 + BEATS + 1 cycles, counting from the request sampled in IDLE to resp_o=1. That is 6 cycles at BEATS=4.
REQ-017 resp_i in IDLE or DONE SHALL be ignored and SHALL NOT change state, k or line_o.
REQ-018 burst_o SHALL be 0 outside WRITE.

Reset
REQ-019 While rst=1 at posedge, the block SHALL enter IDLE with:
- k=0
- line_o=0, buffer=0
- address_o=0
- read_o, write_o and resp_o all 0
REQ-020 Reset mid-burst SHALL abort the transfer with no resp_o. Any partially captured line_o SHALL be cleared.
REQ-021 The first request after reset is released SHALL be accepted normally.

Verification
REQ-022 Read, zero-gap: read_i=1, address_i=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i cycles. Required response:
- address_o = 0x0000_1220
- read_o high for exactly 4 cycles
- resp_o pulses in cycle 6
- line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}
REQ-023 Write with stalls: write_i=1, line_i = {D3,D2,D1,D0}; resp_i pattern 1,0,0,1,1,0,1. Required response:
- burst_o presents D0, D1, D1, D1, D2, D3, D3 in those cycles
- write_o drops after the 4th accept
- resp_o is a single pulse
REQ-024 Simultaneous read_i=1 and write_i=1 in IDLE: WRITE SHALL be entered, read_o SHALL stay 0, and the write burst SHALL complete.
REQ-025 Back-to-back: read_i held high through DONE. After the resp_o pulse, IDLE SHALL be visited for one cycle and read_o SHALL re-assert the following cycle. line_o SHALL keep the old line until the new beat 0 arrives.
REQ-026 Reset after 2 read beats: line_o=0, read_o=0, no resp_o. A subsequent read SHALL complete with k starting at 0.
REQ-027 Spurious resp_i=1 while IDLE: no state change, line_o unchanged, resp_o remains 0.
